inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit_pkg.sv | 15 +
 rtl/inst_fetch_unit_pc_reg.sv | 18 +
 rtl/inst_fetch_unit.sv | 58 +++++
 tb/tb_inst_fetch_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared datapath width, FSM state encodings and the PC increment for the fetch unit
package inst_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
    VALID = 2'd2,
    FAULT = 2'd3
`else
    VALID = 2'd2
`endif
  } state_t;
endpackage

// File: rtl/inst_fetch_unit_pc_reg.sv
// pc_reg: program counter with priority rst > load > inc (clk, rst, load, target, inc -> pc)
module pc_reg
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= target;
    else if (inc) pc <= pc + PC_INC;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: IDLE/ADDR/VALID fetch FSM with ir; ports clk, rst, fetch_req, inst_ack, pc_load, pc_target, imem_inst -> imem_addr, ir, pc, inst_valid, busy, misalign; FETCH_MISALIGN_TRAP_EN adds a FAULT state for misaligned fetches
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  input  logic            inst_ack,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] imem_inst,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] pc,
  output logic            inst_valid,
  output logic            busy,
  output logic            misalign
);
  state_t state;
  logic [XLEN-1:0] target;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign target   = pc_target;
  assign misalign = state == FAULT;
`else
  // without the trap, redirects are forced word-aligned so a misaligned pc can never be fetched
  assign target   = pc_target & ~32'h3;
  assign misalign = 1'b0;
`endif
  assign imem_addr  = pc;
  assign inst_valid = state == VALID;
  assign busy       = state != IDLE;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(pc_load), .target(target), .inc(state == ADDR), .pc(pc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ir    <= '0;
    end else
      case (state)
`ifdef FETCH_MISALIGN_TRAP_EN
        IDLE:  if (!pc_load && fetch_req) state <= |pc[1:0] ? FAULT : ADDR;
        FAULT: if (pc_load) state <= IDLE;
`else
        IDLE:  if (!pc_load && fetch_req) state <= ADDR;
`endif
        ADDR:
          if (pc_load) state <= IDLE;
          else begin
            ir    <= imem_inst;
            state <= VALID;
          end
        VALID: if (inst_ack) state <= (fetch_req && !pc_load) ? ADDR : IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of inst_fetch_unit against hand-computed values
module tb_inst_fetch_unit;
  logic clk = 1'b0;
  logic rst, fetch_req, inst_ack, pc_load;
  logic [31:0] pc_target, imem_inst, imem_addr, ir, pc;
  logic inst_valid, busy, misalign;
  int tests = 0, fails = 0;
  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .inst_ack(inst_ack), .pc_load(pc_load),
    .pc_target(pc_target), .imem_inst(imem_inst), .imem_addr(imem_addr), .ir(ir), .pc(pc),
    .inst_valid(inst_valid), .busy(busy), .misalign(misalign)
  );
  always #5 clk = ~clk;
  assign imem_inst = imem_addr == 32'h0 ? 32'h014B4820 : imem_addr ^ 32'hA5A5_0000;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1; fetch_req = 0; inst_ack = 0; pc_load = 0; pc_target = '0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    rst = 0;
    fetch_req = 1; step();
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_addr", imem_addr, 32'h0);
    chk("f1_valid_early", 32'(inst_valid), 32'd0);
    fetch_req = 0; step();
    chk("f1_ir", ir, 32'h014B4820);
    chk("f1_valid", 32'(inst_valid), 32'd1);
    chk("f1_pc", pc, 32'h4);
    step();
    chk("f1_hold_valid", 32'(inst_valid), 32'd1);
    inst_ack = 1; step(); inst_ack = 0;
    chk("f1_ack_busy", 32'(busy), 32'd0);
    chk("f1_ack_valid", 32'(inst_valid), 32'd0);
    chk("f1_ir_hold", ir, 32'h014B4820);
    rst = 1; step(); rst = 0;
    fetch_req = 1; inst_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("b2b_addr%0d", i), imem_addr, 32'(4 * i));
      if (i == 2) fetch_req = 0;
      step();
      chk($sformatf("b2b_valid%0d", i), 32'(inst_valid), 32'd1);
      chk($sformatf("b2b_ir%0d", i), ir, i == 0 ? 32'h014B4820 : 32'(4 * i) ^ 32'hA5A5_0000);
    end
    step(); inst_ack = 0;
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_pc", pc, 32'd12);
    fetch_req = 1; step(); fetch_req = 0;
    chk("ab_addr", imem_addr, 32'd12);
    pc_load = 1; pc_target = 32'h40; step(); pc_load = 0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ir", ir, 32'hA5A5_0008);
    chk("ab_pc", pc, 32'h40);
    chk("ab_valid", 32'(inst_valid), 32'd0);
    fetch_req = 1; step(); fetch_req = 0;
    chk("ab_refetch_addr", imem_addr, 32'h40);
    step();
    chk("ab_refetch_ir", ir, 32'hA5A5_0040);
    inst_ack = 1; step(); inst_ack = 0;
    pc_load = 1; pc_target = 32'hFFFF_FFFC; fetch_req = 1; step(); pc_load = 0;
    chk("wr_load_ignores_req", 32'(busy), 32'd0);
    chk("wr_pc", pc, 32'hFFFF_FFFC);
    step();
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_pc_wrap", pc, 32'h0);
    chk("wr_ir", ir, 32'h5A5A_FFFC);
    inst_ack = 1; pc_load = 1; pc_target = 32'h100; step();
    inst_ack = 0; pc_load = 0; fetch_req = 0;
    chk("vl_busy", 32'(busy), 32'd0);
    chk("vl_pc", pc, 32'h100);
    chk("vl_ir", ir, 32'h5A5A_FFFC);
    fetch_req = 1; step();
    chk("ra_busy", 32'(busy), 32'd1);
    rst = 1; pc_load = 1; pc_target = 32'h80; step();
    rst = 0; pc_load = 0; fetch_req = 0;
    chk("ra_pc", pc, 32'h0);
    chk("ra_valid", 32'(inst_valid), 32'd0);
    chk("ra_busy_after", 32'(busy), 32'd0);
    chk("ra_ir", ir, 32'h0);
    pc_load = 1; pc_target = 32'h42; step(); pc_load = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_pc", pc, 32'h42);
    fetch_req = 1; step(); step(); fetch_req = 0;
    chk("ma_flag", 32'(misalign), 32'd1);
    chk("ma_ir", ir, 32'h0);
    chk("ma_valid", 32'(inst_valid), 32'd0);
    pc_load = 1; pc_target = 32'h44; step(); pc_load = 0;
    chk("ma_clear", 32'(misalign), 32'd0);
    chk("ma_idle", 32'(busy), 32'd0);
    chk("ma_pc44", pc, 32'h44);
`else
    chk("al_pc", pc, 32'h40);
    fetch_req = 1; step(); fetch_req = 0;
    chk("al_misalign", 32'(misalign), 32'd0);
    chk("al_addr", imem_addr, 32'h40);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
